// File: rtl/integral_image_acc.sv
// Streaming integral-image generator: one integral value per raster-order pixel,
// built from a running row sum plus a one-row line memory of previous-row integrals.
module integral_image_acc #(
    parameter int IMG_WIDTH  = 40,
    parameter int IMG_HEIGHT = 30,
    parameter int DIN        = 8,
    parameter int DOUT       = 19
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DIN-1:0]  din_data,
    input  logic            din_valid,
    output logic            din_ready,
    output logic [DOUT:0]   dout_data,
    output logic            dout_valid,
    input  logic            dout_ready
);

    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [DOUT-1:0] row_sum;
    logic [DOUT-1:0] line_mem [IMG_WIDTH];

    logic            accept;
    logic            x_last;
    logic            y_last;
    logic            frame_last;
    logic [DOUT-1:0] rs;
    logic [DOUT-1:0] above;
    logic [DOUT-1:0] ii;

    // Single output register: a new pixel may enter only if that register frees up.
    assign din_ready  = !dout_valid || dout_ready;
    assign accept     = din_valid && din_ready;
    assign x_last     = (x == X_LAST);
    assign y_last     = (y == Y_LAST);
    assign frame_last = x_last && y_last;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        rs    = DOUT'(din_data);
        above = '0;
        if (x != '0) begin
            rs = row_sum + DOUT'(din_data);
        end
        if (y != '0) begin
            above = line_mem[x];
        end
        ii = rs + above;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x          <= '0;
            y          <= '0;
            row_sum    <= '0;
            dout_data  <= '0;
            dout_valid <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (accept) begin
                row_sum    <= rs;
                dout_data  <= {frame_last, ii};
                dout_valid <= 1'b1;
                if (x_last) begin
                    x <= '0;
                    y <= y_last ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

    // NOTE: the line memory has no reset; row 0 masks its contents, so stale data is never used.
    // The combinational read above sees the old entry, so this write only affects the next row.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_mem[x] <= ii;
        end
    end

endmodule

// File: tb/tb_integral_image_acc.sv
// Scoreboard bench for integral_image_acc: a 4x3 instance for directed/stall/reset/random
// cases and a default-size instance for the full-frame 255 case.
module tb_integral_image_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // small 4x3 instance
    logic [7:0]  din_data   = '0;
    logic        din_valid  = 1'b0;
    logic        din_ready;
    logic [19:0] dout_data;
    logic        dout_valid;
    logic        dout_ready = 1'b1;

    // default 40x30 instance
    logic [7:0]  d_din_data  = '0;
    logic        d_din_valid = 1'b0;
    logic        d_din_ready;
    logic [19:0] d_dout_data;
    logic        d_dout_valid;
    logic        d_dout_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [19:0] q_s [$];
    logic [19:0] q_d [$];
    bit          mon_en     = 1'b0;
    bit          force_low  = 1'b0;
    bit          rand_ready = 1'b0;
    int          out_count  = 0;

    int ones_tab [12] = '{1, 2, 3, 4, 2, 4, 6, 8, 3, 6, 9, 12};
    int ramp_tab [12] = '{0, 1, 3, 6, 4, 10, 18, 28, 12, 27, 45, 66};

    integral_image_acc #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .DIN(8), .DOUT(19)) dut_s (
        .clk(clk), .rst(rst),
        .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
        .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    integral_image_acc dut_d (
        .clk(clk), .rst(rst),
        .din_data(d_din_data), .din_valid(d_din_valid), .din_ready(d_din_ready),
        .dout_data(d_dout_data), .dout_valid(d_dout_valid), .dout_ready(d_dout_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // dout_ready changes shortly after posedge, so it is stable at every negedge
    always @(posedge clk) begin
        #2;
        if (force_low)       dout_ready = 1'b0;
        else if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
        else                 dout_ready = 1'b1;
    end

    logic [19:0] held;
    bit          was_stall = 1'b0;

    always @(negedge clk) begin
        if (!mon_en || rst) begin
            was_stall = 1'b0;
        end else begin
            if (was_stall) begin
                check("hold_valid", 32'(dout_valid), 32'd1);
                check("hold_data", 32'(dout_data), 32'(held));
            end
            was_stall = dout_valid && !dout_ready;
            held      = dout_data;
            if (dout_valid && dout_ready) begin
                if (q_s.size() == 0) check("unexpected_out", 32'(dout_data), 32'hFFFF_FFFF);
                else check("out_data", 32'(dout_data), 32'(q_s.pop_front()));
                out_count++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && d_dout_valid && d_dout_ready) begin
            if (q_d.size() == 0) check("d_unexpected_out", 32'(d_dout_data), 32'hFFFF_FFFF);
            else check("d_out_data", 32'(d_dout_data), 32'(q_d.pop_front()));
        end
    end

    task automatic send_s(input logic [7:0] p, input logic [19:0] exp, input bit push);
        bit ok = 1'b0;
        int budget = 0;
        if (push) q_s.push_back(exp);
        @(negedge clk);
        din_valid = 1'b1;
        din_data  = p;
        do begin
            #1 ok = din_ready;
            @(posedge clk);
            if (!ok) begin
                @(negedge clk);
                budget++;
            end
        end while (!ok && budget < 100);
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_d(input logic [7:0] p, input logic [19:0] exp);
        bit ok = 1'b0;
        int budget = 0;
        q_d.push_back(exp);
        @(negedge clk);
        d_din_valid = 1'b1;
        d_din_data  = p;
        do begin
            #1 ok = d_din_ready;
            @(posedge clk);
            if (!ok) begin
                @(negedge clk);
                budget++;
            end
        end while (!ok && budget < 100);
        if (!ok) check("d_send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_valid = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic drain();
        int budget = 0;
        idle(1);
        while ((q_s.size() != 0 || q_d.size() != 0) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("drain_small", 32'(q_s.size()), 32'd0);
        check("drain_default", 32'(q_d.size()), 32'd0);
    endtask

    task automatic frame_ones(input bit push, input bit gaps);
        for (int i = 0; i < 12; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            send_s(8'd1, {(i == 11), 19'(ones_tab[i])}, push);
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_dout_data", 32'(dout_data), 32'd0);
        check("rst_din_ready", 32'(din_ready), 32'd1);
        check("rst_d_dout_valid", 32'(d_dout_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 mon_en = 1'b1;

        // 12 ones
        frame_ones(1'b1, 1'b0);
        drain();

        // ramp with 5-cycle output stall after the 3rd output
        out_count = 0;
        fork
            begin
                for (int i = 0; i < 12; i++)
                    send_s(8'(i), {(i == 11), 19'(ramp_tab[i])}, 1'b1);
            end
            begin
                int budget = 0;
                while (out_count < 3 && budget < 50) begin
                    @(negedge clk);
                    budget++;
                end
                check("stall_reached", 32'(out_count >= 3), 32'd1);
                force_low = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    #1 check("stall_din_ready", 32'(din_ready), 32'd0);
                end
                force_low = 1'b0;
            end
        join
        drain();

        // back-to-back frames
        frame_ones(1'b1, 1'b0);
        frame_ones(1'b1, 1'b0);
        drain();

        // reset after 6 accepts, then a clean frame
        mon_en = 1'b0;
        for (int i = 0; i < 6; i++) send_s(8'd1, 20'd0, 1'b0);
        @(negedge clk);
        din_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 check("reset_drops_output", 32'(dout_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        q_s.delete();
        #1 mon_en = 1'b1;
        frame_ones(1'b1, 1'b0);
        drain();

        // random input gaps and random output ready
        rand_ready = 1'b1;
        frame_ones(1'b1, 1'b1);
        frame_ones(1'b1, 1'b1);
        drain();
        rand_ready = 1'b0;

        // default-size frame of 255
        for (int y = 0; y < 30; y++)
            for (int x = 0; x < 40; x++)
                send_d(8'd255, {(x == 39 && y == 29), 19'(255 * (x + 1) * (y + 1))});
        @(negedge clk);
        d_din_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
